sha256_arbiter: RTL and testbench
=================================

Name: sha256_arbiter

Overview:
Shares one sha256 core between NREQ byte-stream requesters, for example the receiver hash path and a sender-side hash path. It grants the core to one requester for a whole message and routes the matching digest back to that requester only. It tracks at most one message in flight, which guarantees unambiguous response routing. It sits between the requester FSMs and the sha256 instance.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 4096, maximum cycles in WAIT_HASH before the message is abandoned with an error response

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester byte valid
req_last  in  NREQ  per-requester last-byte flag
req_data  in  8*NREQ  per-requester byte; requester i occupies [8i+7:8i]
req_id  in  32*NREQ  per-requester message id; sampled on the last byte
req_ready  out  NREQ  per-requester byte accept
sha_valid  out  1  to core valid
sha_last  out  1  to core last
sha_data  out  8  to core data
sha_id  out  32  to core id
sha_ready  in  1  from core ready
sha_out_valid  in  1  from core out_valid
sha_out_id  in  32  from core out_id
sha_out_len  in  61  from core out_len
sha_out_hash  in  256  from core out_hash
rsp_valid  out  NREQ  one-cycle digest strobe to the owning requester
rsp_err  out  1  qualifies rsp_valid; 1 = timeout, hash invalid
rsp_id  out  32  id of the returned message
rsp_len  out  61  message length reported by the core
rsp_hash  out  256  digest
grant  out  clog2(NREQ)  current or last owner index
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous, active-low, and may assert in any state, including mid-message or mid-wait.
  - Reset values: state=IDLE, grant=0, rr_ptr=0, all rsp_* = 0, busy=0.
  - The in-flight message is dropped. No rsp_valid is produced for it.
- States: IDLE, STREAM, WAIT_HASH.
- IDLE:
  - If any req_valid is set, select the first set bit searching from rr_ptr, wrapping modulo NREQ.
  - Register the selection into grant and go to STREAM. Arbitration costs exactly 1 cycle.
  - req_ready = 0 for all requesters in IDLE.
- STREAM: combinational mux of the granted requester onto the core.
  - sha_valid = req_valid[grant], sha_last = req_last[grant], sha_data = req_data[grant], sha_id = req_id[grant].
  - req_ready[grant] = sha_ready; every other req_ready = 0.
  - The grant is locked until last is transferred. A requester deasserting valid mid-message keeps the grant; no preemption.
  - A transfer is valid & ready. A transfer with last=1 latches req_id into pend_id, clears the wait counter, and goes to WAIT_HASH.
- Outside STREAM: sha_valid = 0 and sha_last = 0. sha_data and sha_id hold the granted requester's inputs.
- WAIT_HASH:
  - req_ready = 0 for all requesters.
  - Match condition: sha_out_valid && sha_out_id == pend_id.
    - Registered outputs: rsp_valid[grant] = 1 for exactly one cycle, rsp_err = 0, rsp_hash/len/id from the core.
    - rr_ptr = grant + 1 mod NREQ; next state IDLE.
  - sha_out_valid with a non-matching id is ignored.
  - Wait counter reaches TIMEOUT-1 with no match:
    - rsp_valid[grant] = 1, rsp_err = 1, rsp_hash = 0, rsp_len = 0, rsp_id = pend_id.
    - rr_ptr advances as on a match; next state IDLE.
  - Match and timeout in the same cycle: the match wins.
- rsp_hash, rsp_len and rsp_id hold their values until the next response. rsp_valid is 0 at all other times.
- Response latency is 1 cycle after the matching sha_out_valid.
- A new arbitration may occur in the cycle after the rsp_valid cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.

Test Plan:
- Req0 sends "abc" (0x61,0x62,0x63, last on 0x63), id=0x11 -> one rsp_valid[0] pulse; rsp_hash[255:192]=64'hba7816bf8f01cfea, rsp_len=3, rsp_id=0x11, rsp_err=0; rsp_valid[1] never asserts.
- Req0 and req1 both valid from reset, each sending 20 bytes, ids 0xA0 and 0xB1 -> req0 is served first (rr_ptr=0), then req1. No byte interleaving at the core; the sha_data sequence equals req0's bytes followed by req1's bytes. Responses come back in order with the correct ids.
- Req1 drops valid for 5 cycles mid-message while req0 is valid -> grant stays 1, req_ready[0]=0 throughout, and req1's message completes intact.
- In WAIT_HASH, inject sha_out_valid with out_id=0xDEAD while pend_id=0x11 -> no response. The later matching out_valid produces the response.
- TIMEOUT=16 and the core never returns a digest -> after 16 cycles in WAIT_HASH: rsp_valid[grant]=1, rsp_err=1, rsp_hash=0; next cycle the block is back in IDLE with busy=0.
- Assert rstn low at byte 7 of a 20-byte message -> all outputs take reset values asynchronously and no response is produced. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/sha256_arbiter.sv
// sha256_arbiter: shares one byte-stream sha256 core between NREQ requesters.
// A requester owns the core for a whole message; the arbiter keeps exactly one
// message in flight and returns the digest (or a timeout error) to the owner.
module sha256_arbiter #(
   parameter  int NREQ    = 2,
   parameter  int TIMEOUT = 4096,
   localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_last,
   input  logic [8*NREQ-1:0]    req_data,
   input  logic [32*NREQ-1:0]   req_id,
   output logic [NREQ-1:0]      req_ready,
   output logic                 sha_valid,
   output logic                 sha_last,
   output logic [7:0]           sha_data,
   output logic [31:0]          sha_id,
   input  logic                 sha_ready,
   input  logic                 sha_out_valid,
   input  logic [31:0]          sha_out_id,
   input  logic [60:0]          sha_out_len,
   input  logic [255:0]         sha_out_hash,
   output logic [NREQ-1:0]      rsp_valid,
   output logic                 rsp_err,
   output logic [31:0]          rsp_id,
   output logic [60:0]          rsp_len,
   output logic [255:0]         rsp_hash,
   output logic [GW-1:0]        grant,
   output logic                 busy
);

   localparam int SW = GW + 1;
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [SW-1:0]   NREQ_W  = SW'(NREQ);
   localparam logic [CW-1:0]   CNT_LIM = CW'(TIMEOUT - 1);
   localparam logic [NREQ-1:0] ONE_W   = NREQ'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_WAIT   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_q, rr_d;
   logic [31:0]     pend_id_q, pend_id_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic [31:0]     rsp_id_q, rsp_id_d;
   logic [60:0]     rsp_len_q, rsp_len_d;
   logic [255:0]    rsp_hash_q, rsp_hash_d;

   logic [2*NREQ-1:0] dbl_s;
   logic [NREQ-1:0]   rot_s;
   logic [SW-1:0]     off_s, sum_s, nxt_s;
   logic              pick_found_s;
   logic [GW-1:0]     pick_idx_s, rr_next_s;
   logic              sel_valid_s, sel_last_s;
   logic [7:0]        sel_data_s;
   logic [31:0]       sel_id_s;
   logic              xfer_last_s, match_s;

   // Round-robin pick: rotate the valid vector so rr_q sits at bit 0, take the first set bit.
   always_comb begin
      dbl_s        = {req_valid, req_valid} >> rr_q;
      rot_s        = dbl_s[NREQ-1:0];
      pick_found_s = 1'b0;
      off_s        = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!pick_found_s && rot_s[k]) begin
            pick_found_s = 1'b1;
            off_s        = SW'(k);
         end else begin
            pick_found_s = pick_found_s;
         end
      end
      sum_s = {1'b0, rr_q} + off_s;
      if (sum_s >= NREQ_W) begin
         sum_s = sum_s - NREQ_W;
      end else begin
         sum_s = sum_s;
      end
      pick_idx_s = sum_s[GW-1:0];
      nxt_s      = {1'b0, grant_q} + SW'(1);
      if (nxt_s >= NREQ_W) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = nxt_s[GW-1:0];
      end
   end

   // Route the granted requester onto the core and its ready back to it.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      sel_data_s  = 8'h00;
      sel_id_s    = 32'h0000_0000;
      req_ready   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q == GW'(i)) begin
            sel_valid_s  = req_valid[i];
            sel_last_s   = req_last[i];
            sel_data_s   = req_data[8*i +: 8];
            sel_id_s     = req_id[32*i +: 32];
            req_ready[i] = (state_q == S_STREAM) ? sha_ready : 1'b0;
         end else begin
            req_ready[i] = 1'b0;
         end
      end
      sha_valid   = (state_q == S_STREAM) ? sel_valid_s : 1'b0;
      sha_last    = (state_q == S_STREAM) ? sel_last_s : 1'b0;
      sha_data    = sel_data_s;
      sha_id      = sel_id_s;
      xfer_last_s = sha_valid & sha_ready & sha_last;
      match_s     = sha_out_valid & (sha_out_id == pend_id_q);
   end

   // Next-state logic: arbitration, message lock, digest match and timeout response.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      pend_id_d   = pend_id_q;
      cnt_d       = cnt_q;
      rsp_valid_d = '0;
      rsp_err_d   = rsp_err_q;
      rsp_id_d    = rsp_id_q;
      rsp_len_d   = rsp_len_q;
      rsp_hash_d  = rsp_hash_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found_s) begin
               grant_d = pick_idx_s;
               state_d = S_STREAM;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_STREAM: begin
            if (xfer_last_s) begin
               pend_id_d = sel_id_s;
               cnt_d     = '0;
               state_d   = S_WAIT;
            end else begin
               state_d = S_STREAM;
            end
         end
         S_WAIT: begin
            // A digest arriving in the timeout cycle still wins.
            if (match_s) begin
               rsp_valid_d = ONE_W << grant_q;
               rsp_err_d   = 1'b0;
               rsp_id_d    = sha_out_id;
               rsp_len_d   = sha_out_len;
               rsp_hash_d  = sha_out_hash;
               rr_d        = rr_next_s;
               state_d     = S_IDLE;
            end else if (cnt_q == CNT_LIM) begin
               rsp_valid_d = ONE_W << grant_q;
               rsp_err_d   = 1'b1;
               rsp_id_d    = pend_id_q;
               rsp_len_d   = 61'd0;
               rsp_hash_d  = 256'd0;
               rr_d        = rr_next_s;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and response registers; reset drops any in-flight message.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         rr_q        <= '0;
         pend_id_q   <= 32'h0000_0000;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_id_q    <= 32'h0000_0000;
         rsp_len_q   <= 61'd0;
         rsp_hash_q  <= 256'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         pend_id_q   <= pend_id_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_id_q    <= rsp_id_d;
         rsp_len_q   <= rsp_len_d;
         rsp_hash_q  <= rsp_hash_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_len   = rsp_len_q;
   assign rsp_hash  = rsp_hash_q;
   assign grant     = grant_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_arbiter.sv
// Bench for sha256_arbiter: two requesters, a behavioural byte-stream core and
// a response scoreboard filled when messages are driven.
module tb_sha256_arbiter;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 16;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int           req;
      logic [31:0]  id;
      logic [60:0]  len;
      logic [255:0] hash;
      logic         err;
   } exp_t;
   typedef struct {
      logic [31:0]  id;
      logic [60:0]  len;
      logic [255:0] hash;
   } core_t;

   logic clk = 1'b0;
   logic rstn;
   logic [NREQ-1:0]    req_valid, req_last, req_ready;
   logic [8*NREQ-1:0]  req_data;
   logic [32*NREQ-1:0] req_id;
   logic               sha_valid, sha_last, sha_ready, sha_out_valid;
   logic [7:0]         sha_data;
   logic [31:0]        sha_id, sha_out_id;
   logic [60:0]        sha_out_len;
   logic [255:0]       sha_out_hash;
   logic [NREQ-1:0]    rsp_valid;
   logic               rsp_err, busy;
   logic [31:0]        rsp_id;
   logic [60:0]        rsp_len;
   logic [255:0]       rsp_hash;
   logic [0:0]         grant;

   logic        rv[NREQ];
   logic        rl[NREQ];
   logic [7:0]  rd[NREQ];
   logic [31:0] rid[NREQ];

   exp_t  exp_q[$];
   core_t core_q[$];
   bq_t   log_q;
   bq_t   cur_q;
   int    n_run = 0;
   int    n_fail = 0;
   int    core_lat = 2;
   bit    core_mute = 1'b0;
   bit    inject_go = 1'b0;
   logic [31:0] inject_id = 32'h0;
   int    core_wait = 0;
   bit    lat_chk = 1'b0;
   int    cyc = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]        = rv[i];
         req_last[i]         = rl[i];
         req_data[8*i +: 8]  = rd[i];
         req_id[32*i +: 32]  = rid[i];
      end
   end

   sha256_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_id(req_id),
      .req_ready(req_ready),
      .sha_valid(sha_valid), .sha_last(sha_last), .sha_data(sha_data), .sha_id(sha_id),
      .sha_ready(sha_ready), .sha_out_valid(sha_out_valid), .sha_out_id(sha_out_id),
      .sha_out_len(sha_out_len), .sha_out_hash(sha_out_hash),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_id(rsp_id), .rsp_len(rsp_len),
      .rsp_hash(rsp_hash), .grant(grant), .busy(busy)
   );

   // Digest produced by the behavioural core: the real SHA-256 for "abc", a mixing checksum otherwise.
   function automatic logic [255:0] core_hash(input bq_t m);
      logic [255:0] h;
      if (m.size() == 3 && m[0] == 8'h61 && m[1] == 8'h62 && m[2] == 8'h63)
         return 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
      h = {8{32'h6a09e667}};
      foreach (m[i]) h = {h[250:0], h[255:251]} ^ {248'h0, m[i]};
      return h;
   endfunction

   function automatic bq_t mk_msg(input int seed, input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'(seed * 37 + i * 11 + 1));
      return q;
   endfunction

   // Core side: record every accepted byte, queue a digest on the last byte.
   task automatic xfer_mon();
      forever begin
         @(posedge clk);
         if (rstn !== 1'b1) begin
            cur_q.delete();
         end else if (sha_valid && sha_ready) begin
            cur_q.push_back(sha_data);
            log_q.push_back(sha_data);
            if (sha_last) begin
               if (!core_mute)
                  core_q.push_back('{id: sha_id, len: 61'(cur_q.size()), hash: core_hash(cur_q)});
               cur_q.delete();
            end
         end
      end
   endtask

   // Core side: drive ready with backpressure, return digests after core_lat cycles, inject stray ids.
   task automatic core_proc();
      forever begin
         @(negedge clk);
         cyc++;
         sha_out_valid = 1'b0;
         sha_ready     = ((cyc % 4) != 3);
         if (lat_chk) begin
            lat_chk = 1'b0;
            n_run++;
            if (rsp_valid === 2'b00) begin
               n_fail++;
               $display("FAIL rsp_latency: rsp_valid=%b one cycle after digest, wanted nonzero", rsp_valid);
            end
         end
         if (inject_go) begin
            inject_go     = 1'b0;
            sha_out_valid = 1'b1;
            sha_out_id    = inject_id;
            sha_out_len   = 61'd99;
            sha_out_hash  = {8{32'hffff_ffff}};
         end else if (core_q.size() > 0) begin
            if (core_wait < core_lat) begin
               core_wait++;
            end else begin
               core_wait     = 0;
               sha_out_valid = 1'b1;
               sha_out_id    = core_q[0].id;
               sha_out_len   = core_q[0].len;
               sha_out_hash  = core_q[0].hash;
               void'(core_q.pop_front());
               lat_chk = 1'b1;
            end
         end
      end
   endtask

   // Scoreboard: every rsp_valid pulse must match the oldest expected response.
   task automatic rsp_mon();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && rsp_valid !== 2'b00) begin
            n_run++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: rsp_valid=%b id=%h, wanted no response", rsp_valid, rsp_id);
            end else begin
               e = exp_q.pop_front();
               if (rsp_valid !== (2'b01 << e.req) || rsp_err !== e.err || rsp_id !== e.id ||
                   rsp_len !== e.len || rsp_hash !== e.hash) begin
                  n_fail++;
                  $display("FAIL rsp_fields: got v=%b err=%b id=%h len=%0d hash=%h, wanted v=%b err=%b id=%h len=%0d hash=%h",
                           rsp_valid, rsp_err, rsp_id, rsp_len, rsp_hash,
                           2'b01 << e.req, e.err, e.id, e.len, e.hash);
               end
            end
         end
      end
   endtask

   // Requester r streams message m; optional valid gap after gap_at bytes; stops after stop_at bytes.
   task automatic send_msg(input int r, input bq_t m, input logic [31:0] id,
                           input int gap_at, input int gap_len, input int stop_at);
      int  i = 0;
      int  guard = 0;
      bit  gapped = 1'b0;
      logic [1:0] own = 2'b01 << r;
      while (i < stop_at) begin
         @(negedge clk);
         if (gap_len > 0 && i == gap_at && !gapped) begin
            gapped = 1'b1;
            rv[r]  = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               if (g > 0) @(negedge clk);
               #1;
               n_run++;
               if (grant !== 1'(r) || (req_ready & ~own) !== 2'b00) begin
                  n_fail++;
                  $display("FAIL gap_hold: grant=%0d req_ready=%b, wanted grant=%0d and no other ready", grant, req_ready, r);
               end
            end
            continue;
         end
         rv[r]  = 1'b1;
         rd[r]  = m[i];
         rl[r]  = (i == m.size() - 1);
         rid[r] = id;
         #1;
         if (req_ready[r]) i++;
         guard++;
         if (guard > 3000) begin
            n_fail++;
            $display("FAIL send_timeout: requester %0d stuck at byte %0d, wanted %0d bytes", r, i, stop_at);
            break;
         end
      end
      if (stop_at >= m.size()) begin
         @(negedge clk);
         rv[r] = 1'b0;
         rl[r] = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && g < 400) begin
         @(negedge clk);
         g++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      n_run++;
      if (busy !== 1'b0 || grant !== 1'b0 || rsp_valid !== 2'b00 || rsp_err !== 1'b0 ||
          rsp_id !== 32'h0 || rsp_len !== 61'd0 || rsp_hash !== 256'd0 ||
          sha_valid !== 1'b0 || req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_values: busy=%b grant=%b rsp_valid=%b err=%b id=%h sha_valid=%b req_ready=%b, wanted all 0",
                  busy, grant, rsp_valid, rsp_err, rsp_id, sha_valid, req_ready);
      end
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
   endtask

   task automatic test_back_to_back();
      bq_t m0 = mk_msg(1, 20);
      bq_t m1 = mk_msg(2, 20);
      bq_t e;
      int  bad = 0;
      log_q.delete();
      exp_q.push_back('{req: 0, id: 32'hA0, len: 61'd20, hash: core_hash(m0), err: 1'b0});
      exp_q.push_back('{req: 1, id: 32'hB1, len: 61'd20, hash: core_hash(m1), err: 1'b0});
      fork
         send_msg(0, m0, 32'hA0, 0, 0, 20);
         send_msg(1, m1, 32'hB1, 0, 0, 20);
      join
      wait_idle();
      e = m0;
      foreach (m1[i]) e.push_back(m1[i]);
      if (log_q.size() != e.size()) bad = 1;
      else foreach (e[i]) if (log_q[i] !== e[i]) bad = 1;
      n_run++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL b2b_bytes: core saw %0d bytes, wanted req0 then req1 (%0d bytes) unmixed", log_q.size(), e.size());
      end
      n_run++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_done: %0d responses outstanding, wanted 0", exp_q.size());
      end
   endtask

   task automatic test_abc();
      bq_t m;
      m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
      exp_q.push_back('{req: 0, id: 32'h11, len: 61'd3, hash: core_hash(m), err: 1'b0});
      send_msg(0, m, 32'h11, 0, 0, 3);
      wait_idle();
      n_run++;
      if (rsp_hash[255:192] !== 64'hba7816bf8f01cfea || rsp_len !== 61'd3 ||
          rsp_id !== 32'h11 || rsp_err !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL abc_digest: hash_hi=%h len=%0d id=%h err=%b, wanted ba7816bf8f01cfea 3 11 0",
                  rsp_hash[255:192], rsp_len, rsp_id, rsp_err);
      end
   endtask

   task automatic test_dropout();
      bq_t m0 = mk_msg(3, 10);
      bq_t m1 = mk_msg(4, 15);
      bq_t e;
      int  bad = 0;
      log_q.delete();
      exp_q.push_back('{req: 1, id: 32'hB3, len: 61'd15, hash: core_hash(m1), err: 1'b0});
      exp_q.push_back('{req: 0, id: 32'hA2, len: 61'd10, hash: core_hash(m0), err: 1'b0});
      fork
         send_msg(0, m0, 32'hA2, 0, 0, 10);
         send_msg(1, m1, 32'hB3, 6, 5, 15);
      join
      wait_idle();
      e = m1;
      foreach (m0[i]) e.push_back(m0[i]);
      if (log_q.size() != e.size()) bad = 1;
      else foreach (e[i]) if (log_q[i] !== e[i]) bad = 1;
      n_run++;
      if (bad != 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL dropout_bytes: core saw %0d bytes, wanted req1 intact then req0 (%0d bytes)", log_q.size(), e.size());
      end
   endtask

   task automatic test_bad_id();
      bq_t m = mk_msg(5, 4);
      core_lat = 8;
      exp_q.push_back('{req: 0, id: 32'h11, len: 61'd4, hash: core_hash(m), err: 1'b0});
      send_msg(0, m, 32'h11, 0, 0, 4);
      #2;
      inject_id = 32'hDEAD;
      inject_go = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         n_run++;
         if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_id_ignored: rsp_valid=%b busy=%b, wanted 00 and 1", rsp_valid, busy);
         end
      end
      wait_idle();
      n_run++;
      if (exp_q.size() != 0 || rsp_id !== 32'h11) begin
         n_fail++;
         $display("FAIL bad_id_match: rsp_id=%h outstanding=%0d, wanted 11 and 0", rsp_id, exp_q.size());
      end
      core_lat = 2;
   endtask

   task automatic test_timeout();
      bq_t m = mk_msg(6, 5);
      int  bad = 0;
      core_mute = 1'b1;
      exp_q.push_back('{req: 0, id: 32'h77, len: 61'd0, hash: 256'd0, err: 1'b1});
      send_msg(0, m, 32'h77, 0, 0, 5);
      for (int k = 2; k <= 16; k++) begin
         @(negedge clk);
         if (rsp_valid !== 2'b00 || busy !== 1'b1) bad = 1;
      end
      n_run++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL timeout_early: response or idle before 16 wait cycles, wanted busy with no response");
      end
      @(negedge clk);
      n_run++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_hash !== 256'd0 || rsp_id !== 32'h77) begin
         n_fail++;
         $display("FAIL timeout_rsp: v=%b err=%b id=%h, wanted 01 1 77 with zero hash", rsp_valid, rsp_err, rsp_id);
      end
      @(negedge clk);
      n_run++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_idle: busy=%b rsp_valid=%b, wanted 0 00", busy, rsp_valid);
      end
      core_mute = 1'b0;
   endtask

   task automatic test_reset_mid();
      bq_t m  = mk_msg(7, 20);
      bq_t c0 = mk_msg(8, 6);
      bq_t c1 = mk_msg(9, 6);
      send_msg(1, m, 32'hE1, 0, 0, 7);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      n_run++;
      if (busy !== 1'b0 || grant !== 1'b0 || rsp_valid !== 2'b00 || rsp_err !== 1'b0 ||
          rsp_id !== 32'h0 || rsp_hash !== 256'd0 || sha_valid !== 1'b0 || req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_async: busy=%b grant=%b err=%b id=%h sha_valid=%b req_ready=%b, wanted all 0",
                  busy, grant, rsp_err, rsp_id, sha_valid, req_ready);
      end
      rv[1] = 1'b0;
      rl[1] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      exp_q.push_back('{req: 0, id: 32'hC0, len: 61'd6, hash: core_hash(c0), err: 1'b0});
      exp_q.push_back('{req: 1, id: 32'hC1, len: 61'd6, hash: core_hash(c1), err: 1'b0});
      fork
         send_msg(0, c0, 32'hC0, 0, 0, 6);
         send_msg(1, c1, 32'hC1, 0, 0, 6);
         begin
            int g = 0;
            while (busy !== 1'b1 && g < 100) begin
               @(negedge clk);
               g++;
            end
            n_run++;
            if (grant !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL reset_first_grant: grant=%0d busy=%b, wanted 0 1", grant, busy);
            end
         end
      join
      wait_idle();
   endtask

   initial begin
      rstn          = 1'b0;
      sha_ready     = 1'b0;
      sha_out_valid = 1'b0;
      sha_out_id    = 32'h0;
      sha_out_len   = 61'd0;
      sha_out_hash  = 256'd0;
      for (int i = 0; i < NREQ; i++) begin
         rv[i]  = 1'b0;
         rl[i]  = 1'b0;
         rd[i]  = 8'h00;
         rid[i] = 32'h0;
      end
      fork
         xfer_mon();
         core_proc();
         rsp_mon();
      join_none
      test_reset();
      test_back_to_back();
      test_abc();
      test_dropout();
      test_bad_id();
      test_timeout();
      test_reset_mid();
      repeat (5) @(negedge clk);
      n_run++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL final_drain: %0d responses never arrived, wanted 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
